fetch_unit_rv32i: RTL
=====================

Name: fetch_unit_rv32i

Overview:
- Instruction fetch stage directly upstream of the RV32I instruction decoder.
- Generates the sequential PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch queue and presents {pc, instr} to decode with a valid/ready handshake; if_instr[6:0] drives the decoder opcode input.
- Accepts redirects from branch/jump resolution (branch, jump, i_jump classes): flushes the queue and discards the stale in-flight response.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 2, prefetch queue entries (power of two, >=2).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  request valid; combinational from state.
- imem_addr  output  XLEN  word-aligned fetch address (= fetch_pc).
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid for the oldest outstanding request.
- imem_rdata  input  XLEN  instruction word.
- redirect_valid  input  1  control-flow redirect from execute.
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced 00).
- if_valid  output  1  queue head valid (count != 0).
- if_ready  input  1  decode accepts head this cycle (0 = stall).
- if_pc  output  XLEN  PC of queue head.
- if_instr  output  XLEN  instruction word of queue head.

Behaviour:
- Reset (rst=1 at clk edge):
  - fetch_pc=RESET_PC, state=IDLE, queue count=0, rd/wr pointers=0.
  - Resulting outputs: imem_req=0 during rst, if_valid=0, if_pc/if_instr=0.
  - Reset mid-transaction abandons any outstanding request; a later imem_rvalid in IDLE is ignored.
- States: IDLE, WAIT (one live request outstanding), DROP (one stale request outstanding). At most one request is outstanding.
- IDLE:
  - imem_req = !rst && !redirect_valid && (count < QDEPTH).
  - On imem_req && imem_gnt: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^XLEN, so 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - imem_addr must hold stable while imem_req=1 and gnt=0.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: push {req_pc, imem_rdata}, go to IDLE.
  - Minimum issue interval is 2 cycles; response is visible at if_* the cycle after rvalid (no bypass).
- DROP:
  - imem_req=0.
  - On imem_rvalid: discard data, go to IDLE.
  - Further redirects while in DROP only update fetch_pc.
- Space rule: a request is issued only when count < QDEPTH and state is IDLE. A push therefore never meets a full queue, because the entry was reserved at issue: count counts only filled entries, and IDLE with count==QDEPTH blocks issue.
- Dequeue: on if_valid && if_ready, rd pointer advances. Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1), highest priority:
  - Queue is flushed (count=0, pointers=0) at the edge; if_valid=0 the next cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - IDLE: no request is issued that cycle (imem_req forced 0), so nothing becomes stale. Stay in IDLE.
  - WAIT with rvalid in the same cycle: response discarded, go to IDLE.
  - WAIT without rvalid: go to DROP.
  - A dequeue in the same cycle is still a completed handshake for decode; execute must ensure it is the younger wrong-path instruction.
- if_pc/if_instr are held stable while if_valid && !if_ready.
- No fault or error handling; instruction legality is decided downstream by the decoder.

Test Plan:
- Reset then gnt=1, rvalid one cycle after gnt, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc 0x0,0x4,0x8; data 0x00000033 appears with if_valid one cycle after its rvalid.
- if_ready=0 for 10 cycles, memory always ready -> exactly 2 pushes (0x0, 0x4), then imem_req=0 with addr 0x8 held; on if_ready=1, 0x0 pops first and a fetch resumes.
- Redirect to 0x100 in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> DROP entered; 0xDEADBEEF never appears at if_instr; next imem_addr=0x100; if_pc=0x100.
- Redirect to 0x203 in the same cycle as rvalid -> data dropped; next imem_addr=0x200; queue empty next cycle.
- RESET_PC=0xFFFF_FFF8, two fetches -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst while in WAIT, with rvalid arriving after reset release -> response ignored; first post-reset request is at RESET_PC; if_valid stays 0 until the new response.

Source files
------------

// File: rtl/fetch_unit_rv32i.sv
// RV32I instruction fetch stage: sequential PC generation, single-outstanding
// imem request, small prefetch queue toward decode, redirect flush.
module fetch_unit_rv32i #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;

    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_ent_pc    [QDEPTH];
    logic [XLEN-1:0] w_ent_instr [QDEPTH];

    // Redirect suppresses issue in the same cycle so no request is born stale.
    assign imem_req      = (r_state == S_IDLE) && !rst && !redirect_valid
                           && (r_count < CW'(QDEPTH));
    assign imem_addr     = r_fetch_pc;
    assign w_issue       = imem_req && imem_gnt;
    assign w_push        = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop         = if_valid && if_ready;
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    assign if_valid = (r_count != '0);
    assign if_pc    = if_valid ? w_ent_pc[r_rd_ptr]    : '0;
    assign if_instr = if_valid ? w_ent_instr[r_rd_ptr] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
            logic [XLEN-1:0] r_pc;
            logic [XLEN-1:0] r_instr;
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_pc    <= r_req_pc;
                    r_instr <= imem_rdata;
                end
            end
            assign w_ent_pc[gi]    = r_pc;
            assign w_ent_instr[gi] = r_instr;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_issue) begin
                    r_req_pc   <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
            // A redirect while waiting turns the live request into a stale one.
            case (r_state)
                S_IDLE: if (w_issue) r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid)         r_state <= S_IDLE;
                    else if (redirect_valid) r_state <= S_DROP;
                end
                S_DROP: if (imem_rvalid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
